// File: rtl/alu_seq.sv
// Registered EX-stage ALU with start/done handshake and iterative multiply/divide.
// Define ALU_SEQ_SIGNED_MULDIV_EN to enable signed MULT (14) and DIV (15).
module alu_seq #(
   parameter int WIDTH     = 32,
   parameter int OPT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [OPT_WIDTH-1:0] opt,
   input  logic [WIDTH-1:0]     opr1,
   input  logic [WIDTH-1:0]     opr2,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result,
   output logic [WIDTH-1:0]     result_hi,
   output logic                 illegal_opt,
   output logic                 div_by_zero
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [OPT_WIDTH-1:0] OP_DISABLE = OPT_WIDTH'(0);
   localparam logic [OPT_WIDTH-1:0] OP_ADDU    = OPT_WIDTH'(1);
   localparam logic [OPT_WIDTH-1:0] OP_SUBU    = OPT_WIDTH'(2);
   localparam logic [OPT_WIDTH-1:0] OP_OR      = OPT_WIDTH'(3);
   localparam logic [OPT_WIDTH-1:0] OP_AND     = OPT_WIDTH'(4);
   localparam logic [OPT_WIDTH-1:0] OP_XOR     = OPT_WIDTH'(5);
   localparam logic [OPT_WIDTH-1:0] OP_NOR     = OPT_WIDTH'(6);
   localparam logic [OPT_WIDTH-1:0] OP_SLL     = OPT_WIDTH'(7);
   localparam logic [OPT_WIDTH-1:0] OP_SRL     = OPT_WIDTH'(8);
   localparam logic [OPT_WIDTH-1:0] OP_SRA     = OPT_WIDTH'(9);
   localparam logic [OPT_WIDTH-1:0] OP_SLT     = OPT_WIDTH'(10);
   localparam logic [OPT_WIDTH-1:0] OP_SLTU    = OPT_WIDTH'(11);
   localparam logic [OPT_WIDTH-1:0] OP_MULTU   = OPT_WIDTH'(12);
   localparam logic [OPT_WIDTH-1:0] OP_DIVU    = OPT_WIDTH'(13);
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
   localparam logic [OPT_WIDTH-1:0] OP_MULT    = OPT_WIDTH'(14);
   localparam logic [OPT_WIDTH-1:0] OP_DIV     = OPT_WIDTH'(15);
`endif

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t           state;
   logic [SHW-1:0]   count;
   logic [WIDTH-1:0] acc_hi, acc_lo, operand_b;
   logic             neg_res, neg_rem;

   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] single_res;
   logic             single_legal;
   logic             is_mul_op, is_div_op, is_signed_op;
   logic [WIDTH-1:0] mag1, mag2;

   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem_n, div_quo_n, quo_fin, rem_fin;
   logic [2*WIDTH-1:0] prod_raw, prod_fin;

   always_comb begin
      shamt        = opr2[SHW-1:0];
      single_res   = '0;
      single_legal = 1'b1;
      case (opt)
         OP_DISABLE: single_res = '0;
         OP_ADDU:    single_res = opr1 + opr2;
         OP_SUBU:    single_res = opr1 - opr2;
         OP_OR:      single_res = opr1 | opr2;
         OP_AND:     single_res = opr1 & opr2;
         OP_XOR:     single_res = opr1 ^ opr2;
         OP_NOR:     single_res = ~(opr1 | opr2);
         OP_SLL:     single_res = opr1 << shamt;
         OP_SRL:     single_res = opr1 >> shamt;
         OP_SRA:     single_res = $signed(opr1) >>> shamt;
         OP_SLT:     single_res = {{(WIDTH-1){1'b0}}, ($signed(opr1) < $signed(opr2))};
         OP_SLTU:    single_res = {{(WIDTH-1){1'b0}}, (opr1 < opr2)};
         default:    single_legal = 1'b0;
      endcase
   end

   // Signed ops run on magnitudes; the sign is restored when the result is written.
   always_comb begin
      is_mul_op    = (opt == OP_MULTU);
      is_div_op    = (opt == OP_DIVU);
      is_signed_op = 1'b0;
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
      if (opt == OP_MULT) begin
         is_mul_op    = 1'b1;
         is_signed_op = 1'b1;
      end
      if (opt == OP_DIV) begin
         is_div_op    = 1'b1;
         is_signed_op = 1'b1;
      end
`endif
      mag1 = (is_signed_op && opr1[WIDTH-1]) ? -opr1 : opr1;
      mag2 = (is_signed_op && opr2[WIDTH-1]) ? -opr2 : opr2;
   end

   // One shift-add or restoring-divide step; the remainder is always below the
   // divisor, so the borrow bit of the trial subtraction is the compare result.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : {(WIDTH+1){1'b0}});
      prod_raw  = {mul_sum, acc_lo[WIDTH-1:1]};
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, operand_b};
      div_ge    = ~div_diff[WIDTH];
      div_rem_n = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      div_quo_n = {acc_lo[WIDTH-2:0], div_ge};
      prod_fin  = neg_res ? -prod_raw : prod_raw;
      quo_fin   = neg_res ? -div_quo_n : div_quo_n;
      rem_fin   = neg_rem ? -div_rem_n : div_rem_n;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         operand_b   <= '0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         result_hi   <= '0;
         illegal_opt <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  illegal_opt <= 1'b0;
                  div_by_zero <= 1'b0;
                  neg_res     <= is_signed_op & (opr1[WIDTH-1] ^ opr2[WIDTH-1]);
                  neg_rem     <= is_signed_op & opr1[WIDTH-1];
                  if (is_div_op && opr2 == '0) begin
                     done        <= 1'b1;
                     result      <= '1;
                     result_hi   <= opr1;
                     div_by_zero <= 1'b1;
                  end else if (is_mul_op || is_div_op) begin
                     state     <= is_mul_op ? MUL : DIV;
                     busy      <= 1'b1;
                     count     <= SHW'(WIDTH-1);
                     acc_hi    <= '0;
                     acc_lo    <= mag1;
                     operand_b <= mag2;
                  end else begin
                     done        <= 1'b1;
                     result      <= single_legal ? single_res : '0;
                     result_hi   <= '0;
                     illegal_opt <= ~single_legal;
                  end
               end
            end
            MUL: begin
               {acc_hi, acc_lo} <= prod_raw;
               if (count == '0) begin
                  state               <= IDLE;
                  busy                <= 1'b0;
                  done                <= 1'b1;
                  {result_hi, result} <= prod_fin;
               end else begin
                  count <= count - 1'b1;
               end
            end
            DIV: begin
               acc_hi <= div_rem_n;
               acc_lo <= div_quo_n;
               if (count == '0) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  result    <= quo_fin;
                  result_hi <= rem_fin;
               end else begin
                  count <= count - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH=32) against an arithmetic reference model.
// Honours ALU_SEQ_SIGNED_MULDIV_EN the same way the design does.
module tb_alu_seq;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [3:0]    opt;
   logic [W-1:0]  opr1, opr2;
   logic          busy, done, illegal_opt, div_by_zero;
   logic [W-1:0]  result, result_hi;

   int total = 0;
   int bad   = 0;

   alu_seq #(.WIDTH(W), .OPT_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opt(opt),
      .opr1(opr1), .opr2(opr2), .busy(busy), .done(done),
      .result(result), .result_hi(result_hi),
      .illegal_opt(illegal_opt), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected outcome of one operation; lat is the number of post-accept samples until done.
   task automatic ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [W-1:0] hi,
                         output logic ill, output logic dz, output int lat);
      logic [63:0] p;
      longint      sa, sb, sp;
      int          ia, ib;
      int          s;
      r = '0; hi = '0; ill = 1'b0; dz = 1'b0; lat = 1;
      s = int'(b[4:0]);
      case (op)
         4'd0:  r = '0;
         4'd1:  r = a + b;
         4'd2:  r = a - b;
         4'd3:  r = a | b;
         4'd4:  r = a & b;
         4'd5:  r = a ^ b;
         4'd6:  r = ~(a | b);
         4'd7:  r = a << s;
         4'd8:  r = a >> s;
         4'd9:  r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
         4'd10: begin ia = a; ib = b; r = (ia < ib) ? 32'd1 : 32'd0; end
         4'd11: r = (a < b) ? 32'd1 : 32'd0;
         4'd12: begin p = 64'(a) * 64'(b); r = p[31:0]; hi = p[63:32]; lat = W + 1; end
         4'd13: begin
            if (b == 0) begin r = '1; hi = a; dz = 1'b1; end
            else begin r = a / b; hi = a % b; lat = W + 1; end
         end
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
         4'd14: begin
            ia = a; ib = b; sa = ia; sb = ib; sp = sa * sb;
            r = sp[31:0]; hi = sp[63:32]; lat = W + 1;
         end
         4'd15: begin
            ia = a; ib = b;
            if (b == 0) begin r = '1; hi = a; dz = 1'b1; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               r = 32'h8000_0000; hi = '0; lat = W + 1;
            end else begin r = ia / ib; hi = ia % ib; lat = W + 1; end
         end
`else
         default: ill = 1'b1;
`endif
      endcase
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1; opt = op; opr1 = a; opr2 = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Called on the first sample after an accept; lat = -1 on timeout.
   task automatic wait_done(output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; opt = 4'd1; opr1 = 32'h1234; opr2 = 32'h1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      total++;
      if ({busy, done, illegal_opt, div_by_zero} !== 4'b0 || result !== '0 || result_hi !== '0) begin
         bad++;
         $display("[TB] FAIL reset_state: got busy=%b done=%b ill=%b dz=%b r=%h hi=%h required all 0",
                  busy, done, illegal_opt, div_by_zero, result, result_hi);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
      total++;
      if (done !== 1'b1 || result !== 32'h1 || result_hi !== '0 || illegal_opt !== 1'b0 || div_by_zero !== 1'b0) begin
         bad++;
         $display("[TB] FAIL addu_wrap: got done=%b r=%h hi=%h ill=%b dz=%b required 1 00000001 0 0 0",
                  done, result, result_hi, illegal_opt, div_by_zero);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || result !== 32'h1) begin
         bad++;
         $display("[TB] FAIL done_one_cycle: got done=%b r=%h required 0 00000001", done, result);
      end
      issue(4'd9, 32'h8000_0000, 32'h0000_0024);
      total++;
      if (result !== 32'hF800_0000) begin
         bad++;
         $display("[TB] FAIL sra: got %h required f8000000", result);
      end
      issue(4'd10, 32'hFFFF_FFFF, 32'h1);
      total++;
      if (result !== 32'h1) begin
         bad++;
         $display("[TB] FAIL slt: got %h required 00000001", result);
      end
      issue(4'd11, 32'hFFFF_FFFF, 32'h1);
      total++;
      if (result !== 32'h0) begin
         bad++;
         $display("[TB] FAIL sltu: got %h required 00000000", result);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b, er, eh;
      logic         ei, ez;
      int           el;
      logic [3:0]   op;
      for (int i = 0; i < 12; i++) begin
         op = 4'($urandom_range(0, 11));
         a = $urandom; b = $urandom;
         ref_op(op, a, b, er, eh, ei, ez, el);
         issue(op, a, b);
         total++;
         if (done !== 1'b1 || result !== er || result_hi !== eh) begin
            bad++;
            $display("[TB] FAIL back_to_back op=%0d: got done=%b r=%h hi=%h required 1 %h %h",
                     op, done, result, result_hi, er, eh);
         end
      end
   endtask

   // Pulses start with different operands mid-operation; it must have no effect.
   task automatic test_mul_busy();
      int busy_cnt = 0;
      int lat = 0;
      issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      while (done !== 1'b1 && lat < 100) begin
         lat++;
         if (busy === 1'b1) busy_cnt++;
         if (lat == 5) begin start = 1'b1; opt = 4'd1; opr1 = 32'h3; opr2 = 32'h4; end
         if (lat == 6) start = 1'b0;
         @(posedge clk); #1;
      end
      lat++;
      total++;
      if (busy_cnt != W || lat != W + 1 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL multu_timing: got busy_cycles=%0d done_at=%0d busy=%b required %0d %0d 0",
                  busy_cnt, lat, busy, W, W + 1);
      end
      total++;
      if (result_hi !== 32'hFFFF_FFFE || result !== 32'h0000_0001) begin
         bad++;
         $display("[TB] FAIL multu_result: got %h_%h required fffffffe_00000001", result_hi, result);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL multu_ignored_start: got done=%b busy=%b required 0 0", done, busy);
      end
   endtask

   task automatic test_div();
      int lat;
      issue(4'd13, 32'd100, 32'd7);
      wait_done(lat);
      total++;
      if (lat != W + 1 || result !== 32'd14 || result_hi !== 32'd2 || div_by_zero !== 1'b0) begin
         bad++;
         $display("[TB] FAIL divu: got lat=%0d q=%h r=%h dz=%b required %0d 0000000e 00000002 0",
                  lat, result, result_hi, div_by_zero, W + 1);
      end
      issue(4'd13, 32'd5, 32'd0);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || result !== 32'hFFFF_FFFF || result_hi !== 32'd5 || div_by_zero !== 1'b1) begin
         bad++;
         $display("[TB] FAIL divu_zero: got done=%b busy=%b q=%h r=%h dz=%b required 1 0 ffffffff 00000005 1",
                  done, busy, result, result_hi, div_by_zero);
      end
   endtask

   task automatic test_opcode15();
      int lat;
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
      issue(4'd15, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat);
      total++;
      if (lat != W + 1 || result !== 32'hFFFF_FFFD || result_hi !== 32'hFFFF_FFFF) begin
         bad++;
         $display("[TB] FAIL div_signed: got lat=%0d q=%h r=%h required %0d fffffffd ffffffff",
                  lat, result, result_hi, W + 1);
      end
      issue(4'd15, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat);
      total++;
      if (result !== 32'h8000_0000 || result_hi !== 32'h0) begin
         bad++;
         $display("[TB] FAIL div_min_neg1: got q=%h r=%h required 80000000 00000000", result, result_hi);
      end
`else
      issue(4'd15, 32'hFFFF_FFF9, 32'd2);
      lat = 1;
      total++;
      if (done !== 1'b1 || illegal_opt !== 1'b1 || result !== '0 || result_hi !== '0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL illegal_15: got done=%b ill=%b r=%h hi=%h busy=%b required 1 1 0 0 0",
                  done, illegal_opt, result, result_hi, busy);
      end
      issue(4'd1, 32'd3, 32'd4);
      total++;
      if (illegal_opt !== 1'b0 || result !== 32'd7 || lat != 1) begin
         bad++;
         $display("[TB] FAIL flags_clear: got ill=%b r=%h required 0 00000007", illegal_opt, result);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || result_hi !== '0) begin
         bad++;
         $display("[TB] FAIL reset_mid_op: got busy=%b done=%b r=%h hi=%h required 0 0 0 0",
                  busy, done, result, result_hi);
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_abandon: got stray done/busy=%b required 0", seen);
      end
      issue(4'd1, 32'd1, 32'd1);
      total++;
      if (done !== 1'b1 || result !== 32'd2) begin
         bad++;
         $display("[TB] FAIL after_reset_addu: got done=%b r=%h required 1 00000002", done, result);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, er, eh;
      logic         ei, ez;
      int           el, lat;
      logic [3:0]   op;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(0, 2));
         if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 300));
         ref_op(op, a, b, er, eh, ei, ez, el);
         issue(op, a, b);
         wait_done(lat);
         total++;
         if (lat != el || result !== er || result_hi !== eh || illegal_opt !== ei || div_by_zero !== ez) begin
            bad++;
            $display("[TB] FAIL random op=%0d a=%h b=%h: got lat=%0d r=%h hi=%h ill=%b dz=%b required %0d %h %h %b %b",
                     op, a, b, lat, result, result_hi, illegal_opt, div_by_zero, el, er, eh, ei, ez);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; opt = '0; opr1 = '0; opr2 = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_mul_busy();
      test_div();
      test_opcode15();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the single-cycle CPU ALU.
- Adds a start/done handshake, a wider operation set, and iterative unsigned multiply/divide.
- Sits in EX stage; pipeline stalls on busy.
- Single-cycle ops complete in 1 cycle; MULTU/DIVU take WIDTH+1 cycles and return a double-width result on result/result_hi.

Parameters:
- WIDTH, 32, operand/result width; power of two, 8..64.
- OPT_WIDTH, 4, opcode field width; fixed at 4 for the encoding below.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; accepted when start=1 and busy=0.
- opt  input  OPT_WIDTH  operation code, sampled at accept.
- opr1  input  WIDTH  operand A, sampled at accept.
- opr2  input  WIDTH  operand B, sampled at accept.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse; result/result_hi/flags valid that cycle and held until next accept.
- result  output  WIDTH  result, product low half, or quotient.
- result_hi  output  WIDTH  product high half or remainder; 0 for single-cycle ops.
- illegal_opt  output  1  accepted opcode unsupported; valid with done.
- div_by_zero  output  1  DIVU with opr2=0; valid with done.

Behaviour:
- Opcodes:
  - 0 DISABLE, 1 ADDU, 2 SUBU, 3 OR, 4 AND, 5 XOR, 6 NOR, 7 SLL, 8 SRL, 9 SRA.
  - 10 SLT (signed), 11 SLTU, 12 MULTU, 13 DIVU, 14 MULT, 15 DIV.
  - 14 and 15 are legal only with the optional feature.
- Arithmetic: ADDU/SUBU wrap modulo 2^WIDTH, no overflow flag.
- Shifts: amount = opr2[log2(WIDTH)-1:0]; shift opr1.
- SLT/SLTU: result = {0…0, lt}.
- Reset (rst_n=0 at a clk edge): state IDLE, busy=0, done=0, result=0, result_hi=0, illegal_opt=0, div_by_zero=0, counter=0.
  - Applies mid-operation too: the in-flight op is abandoned and no done is produced.
- States: IDLE, MUL, DIV.
- IDLE, single-cycle op accepted at edge N:
  - At edge N+1: result registered, done=1, state remains IDLE.
  - A new start may be accepted at N+1 (back-to-back, one op per cycle).
- IDLE, op 12/13 accepted at edge N:
  - busy=1 from N+1 through N+WIDTH.
  - Internal counter runs WIDTH-1 down to 0, one bit per cycle (shift-add / restoring divide).
  - At edge N+WIDTH+1: done=1, busy=0, state IDLE.
- Exact MULTU: {result_hi, result} = opr1*opr2, full 2*WIDTH product.
- Exact DIVU: result = opr1/opr2, result_hi = opr1%opr2.
- DIVU with opr2=0:
  - Detected at accept; no iteration.
  - done at N+1 with result = all ones, result_hi = opr1, div_by_zero=1.
- Illegal opcode: done at N+1, result=0, result_hi=0, illegal_opt=1, no state change.
- start while busy=1: ignored entirely; operands are not re-sampled.
- DISABLE: result=0, done pulses; not illegal.
- done is exactly one cycle.
- Flags clear at next accept.

Optional Feature:
- Macro: ALU_SEQ_SIGNED_MULDIV_EN.
- When defined:
  - opcode 14 MULT: signed 2*WIDTH product.
  - opcode 15 DIV: signed quotient truncates toward zero; remainder takes dividend's sign.
  - Implementation: magnitudes go through the same iterative datapath with sign fix-up in the final cycle; latency is identical to MULTU/DIVU.
  - MIN/-1 returns quotient MIN, remainder 0.
  - Divide by zero behaves as DIVU, with result_hi = opr1 unchanged.
- When undefined: opcodes 14/15 are illegal (illegal_opt=1, 1-cycle done).

Test Plan:
- Reset then ADDU 0xFFFFFFFF+0x00000002 -> done next cycle, result=0x00000001, result_hi=0, flags 0.
- SRA opr1=0x80000000, opr2=0x00000024 (shift 4) -> result=0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 32 cycles, done at cycle 33, result_hi=0xFFFFFFFE, result=0x00000001; start pulsed mid-op is ignored.
- DIVU 100/7 -> result=14, result_hi=2 after 33 cycles; DIVU 5/0 -> done next cycle, result=0xFFFFFFFF, result_hi=5, div_by_zero=1.
- Opcode 15 without macro -> illegal_opt=1, result=0; with macro, DIV -7/2 -> result=0xFFFFFFFD, result_hi=0xFFFFFFFF.
- rst_n low at cycle 10 of MULTU -> next edge busy=0, no done pulse, outputs 0; following ADDU 1+1 -> 2.
